// File: rtl/ps2_key_display_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_display_sched_pkg
//  Description : Shared constants and state encodings for the PS/2 key
//                history / display refresh sequencer.
//                Contents: PS/2 prefix bytes, blank segment pattern,
//                parser and refresh state enums.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_key_display_sched_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [6:0] SEG_BLANK = 7'h7F;   // active-low, all segments off

    typedef enum logic [1:0] {
        P_IDLE    = 2'd0,
        P_BRK     = 2'd1,
        P_EXT     = 2'd2,
        P_EXT_BRK = 2'd3
    } parser_state_t;

    typedef enum logic [1:0] {
        R_WAIT = 2'd0,
        R_LOAD = 2'd1,
        R_CAPT = 2'd2
    } refresh_state_t;

endpackage : ps2_key_display_sched_pkg
`default_nettype wire

// File: rtl/ps2_make_break_parser.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_make_break_parser
//  Description : Make / break / extended-prefix parser with held-key register.
//                Emits a one-cycle push request for every displayable make code.
//  Ports       : clk, rst (async, active-high), code_in[7:0], code_valid,
//                clear, push_valid, push_code[7:0]
//  Config      : PS2_TYPEMATIC_FILTER_EN - when defined, a make code equal to
//                the currently held key is not pushed (auto-repeat filter).
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_make_break_parser
    import ps2_key_display_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] code_in,
    input  logic       code_valid,
    input  logic       clear,
    output logic       push_valid,
    output logic [7:0] push_code
);

    parser_state_t r_state, w_state_nxt;
    logic [7:0]    r_held, w_held_nxt;
    logic          r_held_valid, w_held_valid_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= P_IDLE;
            r_held       <= 8'h00;
            r_held_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_held       <= w_held_nxt;
            r_held_valid <= w_held_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_held_nxt       = r_held;
        w_held_valid_nxt = r_held_valid;
        push_valid       = 1'b0;
        push_code        = code_in;
        // clear takes priority over a coincident byte, which is dropped
        if (clear) begin
            w_state_nxt      = P_IDLE;
            w_held_valid_nxt = 1'b0;
        end else if (code_valid) begin
            unique case (r_state)
                P_IDLE: begin
                    if (code_in == PS2_BREAK) begin
                        w_state_nxt = P_BRK;
                    end else if (code_in == PS2_EXT) begin
                        w_state_nxt = P_EXT;
                    end else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
                        push_valid = !(r_held_valid && (code_in == r_held));
`else
                        push_valid = 1'b1;
`endif
                        w_held_nxt       = code_in;
                        w_held_valid_nxt = 1'b1;
                    end
                end
                P_BRK: begin
                    if (code_in == r_held) begin
                        w_held_valid_nxt = 1'b0;
                    end
                    w_state_nxt = P_IDLE;
                end
                P_EXT: begin
                    // extended keys are never displayed; only track their break
                    w_state_nxt = (code_in == PS2_BREAK) ? P_EXT_BRK : P_IDLE;
                end
                P_EXT_BRK: begin
                    w_state_nxt = P_IDLE;
                end
                default: begin
                    w_state_nxt = P_IDLE;
                end
            endcase
        end
    end

endmodule : ps2_make_break_parser
`default_nettype wire

// File: rtl/ps2_key_display_sched.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_display_sched
//  Description : Keeps a shift history of the last DEPTH pressed keys and
//                time-multiplexes one external scancode transcoder across
//                DEPTH display slots, latching each slot's two-digit segments.
//  Ports       : clk, rst (async, active-high), code_in[7:0], code_valid,
//                clear, tc_code[7:0] (to transcoder), tc_seg[6:0],
//                tc_seg_second[6:0] (from transcoder), disp_seg[DEPTH*14-1:0],
//                key_count[3:0], slot_idx[2:0]
//  Config      : PS2_TYPEMATIC_FILTER_EN (see ps2_make_break_parser)
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_display_sched
    import ps2_key_display_sched_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int SCAN_DIV = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            code_in,
    input  logic                  code_valid,
    input  logic                  clear,
    output logic [7:0]            tc_code,
    input  logic [6:0]            tc_seg,
    input  logic [6:0]            tc_seg_second,
    output logic [DEPTH*14-1:0]   disp_seg,
    output logic [3:0]            key_count,
    output logic [2:0]            slot_idx
);

    localparam int                DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 2;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]        CNT_MAX  = 4'(DEPTH);
    localparam logic [2:0]        SLOT_MAX = 3'(DEPTH - 1);

    logic                 w_push_valid;
    logic [7:0]           w_push_code;
    logic [7:0]           r_hist [DEPTH];
    logic [7:0]           w_hist_sel;
    logic [DIV_W-1:0]     r_div;
    refresh_state_t       r_rstate, w_rstate_nxt;

    ps2_make_break_parser u_parser (
        .clk        (clk),
        .rst        (rst),
        .code_in    (code_in),
        .code_valid (code_valid),
        .clear      (clear),
        .push_valid (w_push_valid),
        .push_code  (w_push_code)
    );

    // ---------------- history shift register and key count ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_hist[i] <= 8'h00;
            key_count <= 4'd0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) r_hist[i] <= 8'h00;
            key_count <= 4'd0;
        end else if (w_push_valid) begin
            r_hist[0] <= w_push_code;
            for (int i = 1; i < DEPTH; i++) r_hist[i] <= r_hist[i-1];
            if (key_count != CNT_MAX) key_count <= key_count + 4'd1;
        end
    end

    // Slot selector written as a compare loop so DEPTH < 8 never indexes past the array
    always_comb begin
        w_hist_sel = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_idx == 3'(i)) w_hist_sel = r_hist[i];
        end
    end

    // ---------------- refresh FSM ----------------
    always_comb begin
        w_rstate_nxt = r_rstate;
        unique case (r_rstate)
            R_WAIT:  if (r_div == DIV_LAST) w_rstate_nxt = R_LOAD;
            R_LOAD:  w_rstate_nxt = R_CAPT;
            R_CAPT:  w_rstate_nxt = R_WAIT;
            default: w_rstate_nxt = R_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rstate <= R_WAIT;
            r_div    <= '0;
            slot_idx <= 3'd0;
            tc_code  <= 8'h00;
            disp_seg <= {(DEPTH*2){SEG_BLANK}};
        end else begin
            r_rstate <= w_rstate_nxt;
            unique case (r_rstate)
                R_WAIT: begin
                    if (r_div != DIV_LAST) r_div <= r_div + 1'b1;
                end
                R_LOAD: begin
                    tc_code <= w_hist_sel;
                end
                R_CAPT: begin
                    // transcoder is combinational: its output already reflects tc_code
                    for (int i = 0; i < DEPTH; i++) begin
                        if (slot_idx == 3'(i)) disp_seg[14*i +: 14] <= {tc_seg_second, tc_seg};
                    end
                    slot_idx <= (slot_idx == SLOT_MAX) ? 3'd0 : slot_idx + 3'd1;
                    r_div    <= '0;
                end
                default: begin
                    r_div <= '0;
                end
            endcase
            // clear blanks the display but leaves the sweep running
            if (clear) disp_seg <= {(DEPTH*2){SEG_BLANK}};
        end
    end

endmodule : ps2_key_display_sched
`default_nettype wire

// File: tb/tb_ps2_key_display_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_key_display_sched
//  Description : Directed self-checking bench for ps2_key_display_sched with
//                DEPTH=4, SCAN_DIV=4 and a small stand-in transcoder table.
//  Config      : honours PS2_TYPEMATIC_FILTER_EN for the auto-repeat step.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_display_sched;
    import ps2_key_display_sched_pkg::*;

    localparam int DEPTH    = 4;
    localparam int SCAN_DIV = 4;
    localparam logic [DEPTH*14-1:0] ALL_BLANK = {(DEPTH*14){1'b1}};

    logic                clk = 1'b0;
    logic                rst;
    logic [7:0]          code_in;
    logic                code_valid;
    logic                clear;
    logic [7:0]          tc_code;
    logic [6:0]          tc_seg;
    logic [6:0]          tc_seg_second;
    logic [DEPTH*14-1:0] disp_seg;
    logic [3:0]          key_count;
    logic [2:0]          slot_idx;

    int checks = 0;
    int errors = 0;

    ps2_key_display_sched #(.DEPTH(DEPTH), .SCAN_DIV(SCAN_DIV)) dut (
        .clk           (clk),
        .rst           (rst),
        .code_in       (code_in),
        .code_valid    (code_valid),
        .clear         (clear),
        .tc_code       (tc_code),
        .tc_seg        (tc_seg),
        .tc_seg_second (tc_seg_second),
        .disp_seg      (disp_seg),
        .key_count     (key_count),
        .slot_idx      (slot_idx)
    );

    always #5 clk = ~clk;

    // Stand-in transcoder: {second digit, first digit}, active-low
    function automatic logic [13:0] seg_of(input logic [7:0] c);
        case (c)
            8'h45:   seg_of = {7'h7F, 7'b1000000};  // 0
            8'h16:   seg_of = {7'h7F, 7'b1111001};  // 1
            8'h1E:   seg_of = {7'h7F, 7'b0100100};  // 2
            8'h26:   seg_of = {7'h7F, 7'b0110000};  // 3
            8'h25:   seg_of = {7'h7F, 7'b0011001};  // 4
            8'h1C:   seg_of = {7'h7F, 7'b0001000};  // A
            default: seg_of = {7'h7F, 7'h7F};
        endcase
    endfunction

    always_comb {tc_seg_second, tc_seg} = seg_of(tc_code);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves code_valid high so consecutive calls are back-to-back strobes
    task automatic send(input logic [7:0] b);
        code_in    = b;
        code_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle();
        code_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic wait_sweep();
        repeat (30) @(negedge clk);
    endtask

    initial begin
        logic found;
        rst        = 1'b1;
        code_in    = 8'h00;
        code_valid = 1'b0;
        clear      = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_tc_code",   64'(tc_code),   64'h00);
        check("rst_disp",      64'(disp_seg),  64'(ALL_BLANK));
        check("rst_key_count", 64'(key_count), 64'd0);
        check("rst_slot_idx",  64'(slot_idx),  64'd0);
        rst = 1'b0;
        @(negedge clk);

        // single make code appears in slot 0 after a sweep
        send(8'h16); idle();
        check("push1_count", 64'(key_count), 64'd1);
        wait_sweep();
        check("push1_disp", 64'(disp_seg), 64'({{42{1'b1}}, 7'h7F, 7'b1111001}));

        // break of the same key: no push; next 16 pushes in both builds
        send(8'hF0); send(8'h16); idle();
        check("break_count", 64'(key_count), 64'd1);
        send(8'h16); idle();
        check("remake_count", 64'(key_count), 64'd2);

        // clear empties history and blanks display at once
        pulse_clear();
        @(negedge clk);
        check("clear_count", 64'(key_count), 64'd0);
        check("clear_disp",  64'(disp_seg),  64'(ALL_BLANK));

        // extended make/break sequence is discarded, parser back in IDLE
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); idle();
        check("ext_count", 64'(key_count), 64'd0);
        send(8'h1E); idle();
        check("ext_idle_push", 64'(key_count), 64'd1);

        // saturation: oldest key falls off the end
        pulse_clear();
        send(8'h45); send(8'h16); send(8'h1E); send(8'h26); send(8'h25); idle();
        check("sat_count", 64'(key_count), 64'd4);
        wait_sweep();
        check("sat_disp", 64'(disp_seg),
              64'({seg_of(8'h16), seg_of(8'h1E), seg_of(8'h26), seg_of(8'h25)}));

        // auto-repeat
        pulse_clear();
        send(8'h1C); send(8'h1C); send(8'h1C); idle();
`ifdef PS2_TYPEMATIC_FILTER_EN
        check("repeat_count", 64'(key_count), 64'd1);
`else
        check("repeat_count", 64'(key_count), 64'd3);
`endif

        // clear coincident with a byte: clear wins, byte dropped
        code_in    = 8'h16;
        code_valid = 1'b1;
        clear      = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
        clear      = 1'b0;
        @(negedge clk);
        check("clrvld_count", 64'(key_count), 64'd0);
        check("clrvld_disp",  64'(disp_seg),  64'(ALL_BLANK));
        wait_sweep();
        check("clrvld_disp_sweep", 64'(disp_seg), 64'(ALL_BLANK));

        // asynchronous reset during LOAD of slot 1
        send(8'h16); idle();
        wait_sweep();
        found = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (dut.r_rstate == R_LOAD && slot_idx == 3'd1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("load_found", 64'(found), 64'd1);
        check("preload_tc_code", 64'(tc_code), 64'h16);
        rst = 1'b1;
        #1;
        check("arst_tc_code",   64'(tc_code),   64'h00);
        check("arst_slot_idx",  64'(slot_idx),  64'd0);
        check("arst_disp",      64'(disp_seg),  64'(ALL_BLANK));
        check("arst_key_count", 64'(key_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ps2_key_display_sched
`default_nettype wire
